// File: rtl/axi_rw_bridge.sv
// Single-outstanding bridge from the core's simple rw request port to one
// single-beat AXI4 burst (len=0, INCR) with byte-lane placement and strobes.
module axi_rw_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1,
  parameter int AXI_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  // Requester port: rw_valid_i is held until the one-cycle rw_ready_o pulse
  // that reports completion; the next request may follow in the cycle after it.
  input  logic                rw_valid_i,
  output logic                rw_ready_o,
  input  logic                rw_req_i,
  input  logic [ADDR_W-1:0]   rw_addr_i,
  input  logic [1:0]          rw_size_i,
  input  logic [DATA_W-1:0]   rw_wdata_i,
  output logic [DATA_W-1:0]   rw_rdata_o,
  output logic [1:0]          rw_resp_o,
  // AXI channels: a transfer happens on a clock edge where valid and ready are
  // both high; valid and payload stay stable until that edge.
  output logic                axi_ar_valid_o,
  input  logic                axi_ar_ready_i,
  output logic [ADDR_W-1:0]   axi_ar_addr_o,
  output logic [ID_W-1:0]     axi_ar_id_o,
  output logic [7:0]          axi_ar_len_o,
  output logic [2:0]          axi_ar_size_o,
  output logic [1:0]          axi_ar_burst_o,
  output logic [2:0]          axi_ar_prot_o,
  output logic                axi_ar_lock_o,
  output logic [3:0]          axi_ar_cache_o,
  output logic [3:0]          axi_ar_qos_o,
  output logic [USER_W-1:0]   axi_ar_user_o,
  input  logic                axi_r_valid_i,
  output logic                axi_r_ready_o,
  input  logic [DATA_W-1:0]   axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  input  logic                axi_r_last_i,
  input  logic [ID_W-1:0]     axi_r_id_i,
  output logic                axi_aw_valid_o,
  input  logic                axi_aw_ready_i,
  output logic [ADDR_W-1:0]   axi_aw_addr_o,
  output logic [ID_W-1:0]     axi_aw_id_o,
  output logic [7:0]          axi_aw_len_o,
  output logic [2:0]          axi_aw_size_o,
  output logic [1:0]          axi_aw_burst_o,
  output logic [2:0]          axi_aw_prot_o,
  output logic                axi_aw_lock_o,
  output logic [3:0]          axi_aw_cache_o,
  output logic [3:0]          axi_aw_qos_o,
  output logic [USER_W-1:0]   axi_aw_user_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  output logic [DATA_W-1:0]   axi_w_data_o,
  output logic [DATA_W/8-1:0] axi_w_strb_o,
  output logic                axi_w_last_o,
  input  logic                axi_b_valid_i,
  output logic                axi_b_ready_o,
  input  logic [1:0]          axi_b_resp_i,
  input  logic [ID_W-1:0]     axi_b_id_i,
  output logic [2:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t              state;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_addr;
  logic [1:0]          req_size;
  logic [DATA_W-1:0]   req_wdata;
  logic                aw_done;
  logic                w_done;

  logic [OFF_W-1:0]    in_off;
  logic [OFF_W-1:0]    lat_off;
  logic [OFF_W+2:0]    bit_shift;
  logic                misaligned;
  logic [DATA_W-1:0]   size_mask;
  logic [STRB_W-1:0]   nb_mask;
  logic [DATA_W-1:0]   r_lane;
  logic                aw_hs;
  logic                w_hs;
  logic                unused_ok;

  assign in_off     = rw_addr_i[OFF_W-1:0];
  assign lat_off    = req_addr[OFF_W-1:0];
  assign bit_shift  = {lat_off, 3'b000};
  // An access may not spill past the end of the data beat.
  assign misaligned = (32'(in_off) + (32'd1 << rw_size_i)) > 32'(STRB_W);

  always_comb begin
    size_mask = '0;
    nb_mask   = '0;
    case (req_size)
      2'd0: begin size_mask = DATA_W'(64'h0000_0000_0000_00ff); nb_mask = STRB_W'(8'h01); end
      2'd1: begin size_mask = DATA_W'(64'h0000_0000_0000_ffff); nb_mask = STRB_W'(8'h03); end
      2'd2: begin size_mask = DATA_W'(64'h0000_0000_ffff_ffff); nb_mask = STRB_W'(8'h0f); end
      default: begin size_mask = '1; nb_mask = '1; end
    endcase
  end

  assign r_lane = (axi_r_data_i >> bit_shift) & size_mask;
  assign aw_hs  = axi_aw_valid_o && axi_aw_ready_i;
  assign w_hs   = axi_w_valid_o && axi_w_ready_i;

  assign axi_ar_addr_o  = req_addr;
  assign axi_ar_id_o    = ID_W'(AXI_ID);
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_size_o  = {1'b0, req_size};
  assign axi_ar_burst_o = 2'b01;
  assign axi_ar_prot_o  = '0;
  assign axi_ar_lock_o  = 1'b0;
  assign axi_ar_cache_o = '0;
  assign axi_ar_qos_o   = '0;
  assign axi_ar_user_o  = '0;

  assign axi_aw_addr_o  = req_addr;
  assign axi_aw_id_o    = ID_W'(AXI_ID);
  assign axi_aw_len_o   = 8'd0;
  assign axi_aw_size_o  = {1'b0, req_size};
  assign axi_aw_burst_o = 2'b01;
  assign axi_aw_prot_o  = '0;
  assign axi_aw_lock_o  = 1'b0;
  assign axi_aw_cache_o = '0;
  assign axi_aw_qos_o   = '0;
  assign axi_aw_user_o  = '0;

  assign axi_w_data_o = req_wdata << bit_shift;
  assign axi_w_strb_o = nb_mask << lat_off;
  assign axi_w_last_o = 1'b1;

  assign dbg_state_o = state;
  assign unused_ok   = ^{axi_r_id_i, axi_b_id_i, axi_r_last_i};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      req_wr         <= 1'b0;
      req_addr       <= '0;
      req_size       <= '0;
      req_wdata      <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      rw_ready_o     <= 1'b0;
      rw_rdata_o     <= '0;
      rw_resp_o      <= '0;
      axi_ar_valid_o <= 1'b0;
      axi_r_ready_o  <= 1'b0;
      axi_aw_valid_o <= 1'b0;
      axi_w_valid_o  <= 1'b0;
      axi_b_ready_o  <= 1'b0;
    end else begin
      rw_ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // The completion pulse cycle still sees the old request on the bus.
          if (rw_valid_i && !rw_ready_o) begin
            req_wr    <= rw_req_i;
            req_addr  <= rw_addr_i;
            req_size  <= rw_size_i;
            req_wdata <= rw_wdata_i;
            if (misaligned) begin
              rw_resp_o <= 2'b10;
              state     <= S_ERR;
            end else if (rw_req_i) begin
              aw_done        <= 1'b0;
              w_done         <= 1'b0;
              axi_aw_valid_o <= 1'b1;
              axi_w_valid_o  <= 1'b1;
              state          <= S_WR;
            end else begin
              axi_ar_valid_o <= 1'b1;
              state          <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi_ar_ready_i) begin
            axi_ar_valid_o <= 1'b0;
            axi_r_ready_o  <= 1'b1;
            state          <= S_R;
          end
        end
        S_R: begin
          if (axi_r_valid_i) begin
            axi_r_ready_o <= 1'b0;
            rw_rdata_o    <= r_lane;
            rw_resp_o     <= axi_r_resp_i;
            state         <= S_RESP;
          end
        end
        S_WR: begin
          if (aw_hs) begin
            axi_aw_valid_o <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            axi_w_valid_o <= 1'b0;
            w_done        <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axi_b_ready_o <= 1'b1;
            state         <= S_B;
          end
        end
        S_B: begin
          if (axi_b_valid_i) begin
            axi_b_ready_o <= 1'b0;
            rw_resp_o     <= axi_b_resp_i;
            state         <= S_RESP;
          end
        end
        S_RESP, S_ERR: begin
          rw_ready_o <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Bench for axi_rw_bridge: directed and random rw requests against a small
// AXI slave model; expected completions flow through a scoreboard queue.
module tb_axi_rw_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rw_valid_i = 1'b0;
  logic        rw_ready_o;
  logic        rw_req_i = 1'b0;
  logic [63:0] rw_addr_i = '0;
  logic [1:0]  rw_size_i = '0;
  logic [63:0] rw_wdata_i = '0;
  logic [63:0] rw_rdata_o;
  logic [1:0]  rw_resp_o;
  logic        axi_ar_valid_o, axi_ar_ready_i = 1'b0;
  logic [63:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic [2:0]  axi_ar_prot_o;
  logic        axi_ar_lock_o;
  logic [3:0]  axi_ar_cache_o, axi_ar_qos_o;
  logic [0:0]  axi_ar_user_o;
  logic        axi_r_valid_i = 1'b0, axi_r_ready_o;
  logic [63:0] axi_r_data_i = '0;
  logic [1:0]  axi_r_resp_i = '0;
  logic        axi_r_last_i = 1'b0;
  logic [3:0]  axi_r_id_i = '0;
  logic        axi_aw_valid_o, axi_aw_ready_i = 1'b0;
  logic [63:0] axi_aw_addr_o;
  logic [3:0]  axi_aw_id_o;
  logic [7:0]  axi_aw_len_o;
  logic [2:0]  axi_aw_size_o;
  logic [1:0]  axi_aw_burst_o;
  logic [2:0]  axi_aw_prot_o;
  logic        axi_aw_lock_o;
  logic [3:0]  axi_aw_cache_o, axi_aw_qos_o;
  logic [0:0]  axi_aw_user_o;
  logic        axi_w_valid_o, axi_w_ready_i = 1'b0;
  logic [63:0] axi_w_data_o;
  logic [7:0]  axi_w_strb_o;
  logic        axi_w_last_o;
  logic        axi_b_valid_i = 1'b0, axi_b_ready_o;
  logic [1:0]  axi_b_resp_i = '0;
  logic [3:0]  axi_b_id_i = '0;
  logic [2:0]  dbg_state_o;

  axi_rw_bridge dut (
    .clock(clock), .reset(reset),
    .rw_valid_i(rw_valid_i), .rw_ready_o(rw_ready_o), .rw_req_i(rw_req_i),
    .rw_addr_i(rw_addr_i), .rw_size_i(rw_size_i), .rw_wdata_i(rw_wdata_i),
    .rw_rdata_o(rw_rdata_o), .rw_resp_o(rw_resp_o),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_lock_o(axi_ar_lock_o),
    .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_qos_o(axi_ar_qos_o), .axi_ar_user_o(axi_ar_user_o),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_data_i(axi_r_data_i),
    .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_id_o(axi_aw_id_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_lock_o(axi_aw_lock_o),
    .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_qos_o(axi_aw_qos_o), .axi_aw_user_o(axi_aw_user_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i), .axi_w_data_o(axi_w_data_o),
    .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
    .axi_b_id_i(axi_b_id_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] beat;
    logic [1:0]  resp;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    int          d0;
    int          d1;
    int          d2;
  } cfg_t;

  cfg_t        cfg_q[$];
  logic [65:0] exp_q[$];
  logic [63:0] model_rdata = '0;
  int          total = 0;
  int          bad = 0;
  bit          slave_on = 1'b0;
  bit          slave_idle = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every rw_ready_o pulse consumes one expected entry.
  always @(negedge clock) begin
    if (!reset && rw_ready_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(rw_ready_o), 64'd0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("rw_rdata", rw_rdata_o, e[63:0]);
        check("rw_resp", 64'(rw_resp_o), 64'(e[65:64]));
      end
    end
  end

  // No AXI request may appear while no transaction is outstanding.
  always @(negedge clock) begin
    if (slave_on && slave_idle && !reset &&
        (axi_ar_valid_o || axi_aw_valid_o || axi_w_valid_o)) begin
      check("spurious_axi", {61'd0, axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o}, 64'd0);
    end
  end

  // ---------------- AXI slave model ----------------
  task automatic slave_read(input cfg_t c);
    int n;
    n = 0;
    @(negedge clock);
    while (!axi_ar_valid_o) begin
      @(negedge clock);
      n++;
      if (n > 100) begin check("ar_timeout", 64'd0, 64'd1); return; end
    end
    for (int i = 0; i < c.d0; i++) @(negedge clock);
    check("ar_valid_held", 64'(axi_ar_valid_o), 64'd1);
    check("ar_addr", axi_ar_addr_o, c.addr);
    check("ar_size", 64'(axi_ar_size_o), 64'(c.size));
    check("ar_len_burst_id", {44'd0, axi_ar_len_o, axi_ar_burst_o, 6'd0, axi_ar_id_o},
          {44'd0, 8'd0, 2'b01, 6'd0, 4'd0});
    axi_ar_ready_i = 1'b1;
    @(negedge clock);
    axi_ar_ready_i = 1'b0;
    check("ar_valid_drop", 64'(axi_ar_valid_o), 64'd0);
    for (int i = 0; i < c.d1; i++) @(negedge clock);
    axi_r_valid_i = 1'b1;
    axi_r_data_i  = c.beat;
    axi_r_resp_i  = c.resp;
    axi_r_last_i  = 1'b1;
    axi_r_id_i    = 4'($urandom_range(0, 15));
    n = 0;
    while (!axi_r_ready_o) begin
      @(negedge clock);
      n++;
      if (n > 100) begin check("r_timeout", 64'd0, 64'd1); axi_r_valid_i = 1'b0; return; end
    end
    @(negedge clock);
    axi_r_valid_i = 1'b0;
    axi_r_last_i  = 1'b0;
    axi_r_data_i  = {$urandom, $urandom};
  endtask

  task automatic slave_write(input cfg_t c);
    int  aw_cnt, w_cnt, n;
    bit  aw_done, w_done, aw_pend, w_pend;
    aw_cnt = c.d0; w_cnt = c.d1; n = 0;
    aw_done = 0; w_done = 0; aw_pend = 0; w_pend = 0;
    @(negedge clock);
    forever begin
      if (aw_pend) begin
        aw_pend = 0; aw_done = 1; axi_aw_ready_i = 1'b0;
        check("aw_valid_drop", 64'(axi_aw_valid_o), 64'd0);
      end else if (aw_done) begin
        check("aw_valid_stays_low", 64'(axi_aw_valid_o), 64'd0);
      end
      if (w_pend) begin
        w_pend = 0; w_done = 1; axi_w_ready_i = 1'b0;
        check("w_valid_drop", 64'(axi_w_valid_o), 64'd0);
      end else if (w_done) begin
        check("w_valid_stays_low", 64'(axi_w_valid_o), 64'd0);
      end
      if (aw_done && w_done) break;
      check("b_ready_early", 64'(axi_b_ready_o), 64'd0);
      if (!aw_done && axi_aw_valid_o) begin
        if (aw_cnt == 0) begin
          check("aw_addr", axi_aw_addr_o, c.addr);
          check("aw_size", 64'(axi_aw_size_o), 64'(c.size));
          check("aw_len_burst_id", {44'd0, axi_aw_len_o, axi_aw_burst_o, 6'd0, axi_aw_id_o},
                {44'd0, 8'd0, 2'b01, 6'd0, 4'd0});
          axi_aw_ready_i = 1'b1; aw_pend = 1;
        end else aw_cnt--;
      end
      if (!w_done && axi_w_valid_o) begin
        if (w_cnt == 0) begin
          check("w_data", axi_w_data_o, c.exp_wdata);
          check("w_strb", 64'(axi_w_strb_o), 64'(c.exp_strb));
          check("w_last", 64'(axi_w_last_o), 64'd1);
          axi_w_ready_i = 1'b1; w_pend = 1;
        end else w_cnt--;
      end
      @(negedge clock);
      n++;
      if (n > 100) begin
        check("aw_w_timeout", 64'd0, 64'd1);
        axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0;
        return;
      end
    end
    for (int i = 0; i < c.d2; i++) @(negedge clock);
    axi_b_valid_i = 1'b1;
    axi_b_resp_i  = c.resp;
    axi_b_id_i    = 4'($urandom_range(0, 15));
    n = 0;
    while (!axi_b_ready_o) begin
      @(negedge clock);
      n++;
      if (n > 100) begin check("b_timeout", 64'd0, 64'd1); axi_b_valid_i = 1'b0; return; end
    end
    @(negedge clock);
    axi_b_valid_i = 1'b0;
  endtask

  initial begin
    cfg_t c;
    wait (slave_on);
    forever begin
      @(posedge clock);
      #1;
      if (cfg_q.size() != 0) begin
        c = cfg_q.pop_front();
        if (c.wr) slave_write(c);
        else      slave_read(c);
        slave_idle = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; exp_lat <= 0 skips the latency check.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [63:0] beat,
                         input logic [1:0] resp, input int d0, input int d1, input int d2,
                         input int exp_lat, input bit scramble);
    int          nb, off, cyc;
    logic [63:0] wm, rd, ew;
    logic [7:0]  es;
    cfg_t        c;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    wm = '0; rd = '0; ew = '0; es = '0;
    for (int b = 0; b < nb; b++) wm[8*b +: 8] = wdata[8*b +: 8];
    if (off + nb > 8) begin
      exp_q.push_back({2'b10, model_rdata});
    end else begin
      for (int b = 0; b < nb; b++) begin
        rd[8*b +: 8]       = beat[8*(off+b) +: 8];
        ew[8*(off+b) +: 8] = wm[8*b +: 8];
        es[off+b]          = 1'b1;
      end
      if (!wr) model_rdata = rd;
      exp_q.push_back({resp, model_rdata});
      c.wr = wr; c.addr = addr; c.size = size; c.beat = beat; c.resp = resp;
      c.exp_wdata = ew; c.exp_strb = es; c.d0 = d0; c.d1 = d1; c.d2 = d2;
      cfg_q.push_back(c);
      slave_idle = 1'b0;
    end
    rw_valid_i = 1'b1;
    rw_req_i   = wr;
    rw_addr_i  = addr;
    rw_size_i  = size;
    rw_wdata_i = wm;
    @(negedge clock);
    cyc = 1;
    if (scramble) begin
      rw_req_i   = 1'($urandom_range(0, 1));
      rw_addr_i  = {$urandom, $urandom};
      rw_size_i  = 2'($urandom_range(0, 3));
      rw_wdata_i = {$urandom, $urandom};
      rw_valid_i = 1'($urandom_range(0, 1));
    end
    while (!rw_ready_o && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    if (!rw_ready_o) begin
      check("completion_timeout", 64'd0, 64'd1);
      rw_valid_i = 1'b0;
      return;
    end
    if (exp_lat > 0) check("latency", 64'(cyc), 64'(exp_lat));
    @(negedge clock);
    rw_valid_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_valids", {58'd0, rw_ready_o, axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o,
                           axi_r_ready_o, axi_b_ready_o}, 64'd0);
    check("reset_rdata", rw_rdata_o, 64'd0);
    check("reset_resp", 64'(rw_resp_o), 64'd0);
    check("tied_off", {37'd0, axi_ar_prot_o, axi_ar_lock_o, axi_ar_cache_o, axi_ar_qos_o,
                       axi_ar_user_o, axi_aw_prot_o, axi_aw_lock_o, axi_aw_cache_o,
                       axi_aw_qos_o, axi_aw_user_o}, 64'd0);

    // Reset while waiting for read data abandons the transfer without a pulse.
    rw_valid_i = 1'b1; rw_req_i = 1'b0; rw_addr_i = 64'h8000_0020; rw_size_i = 2'd3;
    @(negedge clock);
    check("ar_valid_before_reset", 64'(axi_ar_valid_o), 64'd1);
    axi_ar_ready_i = 1'b1;
    @(negedge clock);
    axi_ar_ready_i = 1'b0;
    rw_valid_i = 1'b0;
    @(negedge clock);
    check("r_ready_before_reset", 64'(axi_r_ready_o), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_valids", {58'd0, rw_ready_o, axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o,
                               axi_r_ready_o, axi_b_ready_o}, 64'd0);
    model_rdata = '0;
    repeat (2) @(negedge clock);
    slave_on = 1'b1;

    // Directed cases.
    run_txn(1'b0, 64'h8000_0010, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 4, 1'b0);
    run_txn(1'b0, 64'h8000_0003, 2'd0, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 4, 1'b0);
    run_txn(1'b1, 64'h8000_0006, 2'd1, 64'hBEEF, 64'd0, 2'b00, 0, 0, 0, 4, 1'b0);
    run_txn(1'b1, 64'h8000_0008, 2'd3, 64'hCAFE_F00D_1234_5678, 64'd0, 2'b00, 3, 0, 0, 0, 1'b0);
    run_txn(1'b1, 64'h8000_0004, 2'd2, 64'hA5A5_5A5A, 64'd0, 2'b11, 0, 2, 1, 0, 1'b0);
    run_txn(1'b0, 64'h8000_0006, 2'd2, 64'd0, 64'h0, 2'b00, 0, 0, 0, 2, 1'b0);
    run_txn(1'b1, 64'h8000_0007, 2'd1, 64'h1234, 64'd0, 2'b00, 0, 0, 0, 2, 1'b0);
    run_txn(1'b0, 64'h8000_0004, 2'd2, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 2'b10, 2, 3, 0, 0, 1'b0);

    // Random traffic with random slave delays, responses and post-latch input churn.
    for (int t = 0; t < 80; t++) begin
      run_txn(1'($urandom_range(0, 1)), {32'h0000_0000, 32'h8000_0000 | 32'($urandom_range(0, 255))},
              2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 0, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rw_bridge.md
Name: axi_rw_bridge

Overview:
Single-outstanding bridge between the core's simple memory request port and the AXI4 master channels that the simulation top exposes to the memory model. It accepts one read or write request of 1/2/4/8 bytes and issues one single-beat AXI burst (len=0, INCR). It performs byte-lane placement and strobe generation, and returns read data and response to the requester. It sits directly upstream of the top-level AXI pins.

Parameters:
ADDR_W, 64, address width on both sides
DATA_W, 64, data width (one beat); byte lanes = DATA_W/8
ID_W, 4, AXI ID width
USER_W, 1, AXI user width
AXI_ID, 0, constant ID driven on AR/AW

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
rw_valid_i  in  1  request valid, held until accepted
rw_ready_o  out  1  one-cycle completion/accept pulse
rw_req_i  in  1  0=read, 1=write
rw_addr_i  in  ADDR_W  byte address
rw_size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B
rw_wdata_i  in  DATA_W  write data, LSB-aligned
rw_rdata_o  out  DATA_W  read data, LSB-aligned, zero-extended
rw_resp_o  out  2  AXI response code for the completed request
axi_ar_valid_o/ready_i/addr_o/id_o/len_o/size_o/burst_o  out/in/out..  1/1/ADDR_W/ID_W/8/3/2  AR channel
axi_r_valid_i/ready_o/data_i/resp_i/last_i/id_i  in/out/in..  1/1/DATA_W/2/1/ID_W  R channel
axi_aw_valid_o/ready_i/addr_o/id_o/len_o/size_o/burst_o  as AR  AW channel
axi_w_valid_o/ready_i/data_o/strb_o/last_o  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  W channel
axi_b_valid_i/ready_o/resp_i/id_i  in/out/in/in  1/1/2/ID_W  B channel
axi_{ar,aw}_prot_o 3, lock_o 1, cache_o 4, qos_o 4, user_o USER_W  out  tied 0

Behaviour:
- Reset: FSM=IDLE; all valid/ready outputs 0; rw_rdata_o=0, rw_resp_o=0; latched request cleared. Reset mid-transaction abandons the AXI transfer immediately. No completion is produced.
- States: IDLE, AR, R, WR, B, RESP, ERR.
- IDLE: if rw_valid_i=1, latch req/addr/size/wdata. Go to ERR if misaligned, else AR (read) or WR (write).
- Misaligned means addr[2:0] + (1<<size) > 8. ERR asserts rw_ready_o one cycle with rw_resp_o=2'b10 and issues no AXI transaction, then returns to IDLE.
- AR: axi_ar_valid_o=1, addr = latched addr, size = latched size, len=0, burst=2'b01. Stable until axi_ar_ready_i; on handshake go to R.
- R: axi_r_ready_o=1. On axi_r_valid_i (last expected=1), capture rw_rdata_o = (r_data >> 8*addr[2:0]) masked to (1<<size) bytes, and rw_resp_o = r_resp. Go to RESP.
- WR: axi_aw_valid_o and axi_w_valid_o both assert on entry. Each deasserts independently after its own handshake, tracked by aw_done/w_done flags. Go to B when both are done, including when both complete in the same cycle.
- W channel: data = wdata << 8*addr[2:0]; strb = ((1<<(1<<size))-1) << addr[2:0]; last=1.
- B: axi_b_ready_o=1. On axi_b_valid_i, rw_resp_o = b_resp; go to RESP.
- RESP: rw_ready_o=1 for exactly one cycle, then IDLE. The requester deasserts or replaces rw_valid_i in the cycle after the pulse.
- rw_valid_i dropping mid-transaction is ignored; the transaction completes and still pulses.
- rw_rdata_o holds its value until the next read completion.
- Non-OKAY AXI responses are passed through unchanged.
- Minimum latency with a zero-wait slave: read = 4 cycles and write = 4 cycles, counted from the rw_valid_i sample edge in IDLE to the rw_ready_o pulse.
- Input changes after latching have no effect.
- No new request is accepted before return to IDLE (single outstanding).
- rid/bid are ignored.

Test Plan:
- 8B read at 0x8000_0010, r_data=0x1122334455667788, zero waits -> AR addr=0x80000010 size=3 len=0. rw_rdata_o=0x1122334455667788, resp=0. rw_ready_o pulses 4 cycles after request.
- 1B read at 0x8000_0003, r_data=0x1122334455667788 -> rw_rdata_o=0x0000000000000055.
- 2B write 0xBEEF at 0x8000_0006 -> w_data=0xBEEF000000000000, w_strb=0xC0, w_last=1, aw size=1. b_resp=0 gives resp=0.
- Write with w_ready=1 immediately and aw_ready delayed 3 cycles -> w_valid drops after 1 cycle, aw_valid held 4 cycles. B entered only after the AW handshake; exactly one rw_ready_o pulse.
- 4B read at 0x8000_0006 -> no ar_valid ever. rw_ready_o pulses with resp=2'b10 two cycles after request.
- Read with r_valid withheld and reset asserted 1 cycle while in R -> next cycle all valids 0 and rw_ready_o=0. A subsequent request issues a fresh AR.
